gpmc_regfile_bridge: RTL and testbench

GPMC_REGFILE_BRIDGE -- requirements
Module: gpmc_regfile_bridge

---
 rtl/gpmc_bridge_pkg.sv | 23 ++
 rtl/gpmc_sync.sv | 27 ++
 rtl/gpmc_regfile_bridge.sv | 138 +++++++++++++
 tb/tb_gpmc_regfile_bridge.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpmc_bridge_pkg.sv
// Shared types and constants for the GPMC register-file bridge.
package gpmc_bridge_pkg;

  localparam int GPMC_AD_W = 16;

  // Bit positions of the active-low strobes inside the synchronized strobe vector
  localparam int STB_W    = 6;
  localparam int STB_ADVN = 0;
  localparam int STB_CSN  = 1;
  localparam int STB_WEN  = 2;
  localparam int STB_OEN  = 3;
  localparam int STB_BE0N = 4;
  localparam int STB_BE1N = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    ACCESS = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4
  } gpmc_state_e;

endpackage

// File: rtl/gpmc_sync.sv
// Multi-stage synchronizer with a synchronous reset value; all bits share one depth
// so that a group of signals stays cycle-aligned after synchronization.
module gpmc_sync #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpmc_regfile_bridge.sv
// GPMC async muxed-bus slave exposing a 16-bit register file. Build with
// GPMC_BRIDGE_BURST_EN defined to auto-increment the address after each access.
module gpmc_regfile_bridge
  import gpmc_bridge_pkg::*;
#(
  parameter int REG_ADDR_W  = 4,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                                  CLK_100M,
  input  logic                                  reset,
  input  logic [GPMC_AD_W-1:0]                  gpmc_ad_in,
  output logic [GPMC_AD_W-1:0]                  gpmc_ad_out,
  output logic                                  gpmc_ad_oe,
  input  logic                                  gpmc_advn,
  input  logic                                  gpmc_csn,
  input  logic                                  gpmc_wen,
  input  logic                                  gpmc_oen,
  input  logic                                  gpmc_be0n,
  input  logic                                  gpmc_be1n,
  output logic [GPMC_AD_W*(2**REG_ADDR_W)-1:0]  regs_q,
  output logic                                  wr_strobe,
  output logic [REG_ADDR_W-1:0]                 wr_addr,
  output logic [3:0]                            led,
  output gpmc_state_e                           state_o
);

  localparam int NREGS = 2**REG_ADDR_W;

  logic [STB_W-1:0]     stb_s;
  logic [GPMC_AD_W-1:0] ad_s;
  logic advn_s, csn_s, wen_s, oen_s, be0n_s, be1n_s;

  gpmc_sync #(.W(STB_W), .STAGES(SYNC_STAGES), .RST_VAL({STB_W{1'b1}})) u_sync_stb (
    .clk_i (CLK_100M),
    .rst_i (reset),
    .d_i   ({gpmc_be1n, gpmc_be0n, gpmc_oen, gpmc_wen, gpmc_csn, gpmc_advn}),
    .q_o   (stb_s)
  );

  gpmc_sync #(.W(GPMC_AD_W), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_ad (
    .clk_i (CLK_100M),
    .rst_i (reset),
    .d_i   (gpmc_ad_in),
    .q_o   (ad_s)
  );

  assign advn_s = stb_s[STB_ADVN];
  assign csn_s  = stb_s[STB_CSN];
  assign wen_s  = stb_s[STB_WEN];
  assign oen_s  = stb_s[STB_OEN];
  assign be0n_s = stb_s[STB_BE0N];
  assign be1n_s = stb_s[STB_BE1N];

  gpmc_state_e           state_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [REG_ADDR_W-1:0] addr_next;
  logic [GPMC_AD_W-1:0]  reg_file_q [NREGS];
  logic [GPMC_AD_W-1:0]  ad_out_q;
  logic                  oe_q;
  logic                  wr_strobe_q;
  logic [REG_ADDR_W-1:0] wr_addr_q;
  logic                  led_wr_q, led_rd_q, led_alive_q;

`ifdef GPMC_BRIDGE_BURST_EN
  assign addr_next = addr_q + 1'b1;
`else
  assign addr_next = addr_q;
`endif

  always_ff @(posedge CLK_100M) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ad_out_q    <= '0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      led_wr_q    <= 1'b0;
      led_rd_q    <= 1'b0;
      led_alive_q <= 1'b0;
      for (int k = 0; k < NREGS; k++) reg_file_q[k] <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      led_alive_q <= 1'b1;
      // Chip-select release overrides everything, aborting any pending write
      if (csn_s) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (!advn_s) begin
            addr_q  <= ad_s[REG_ADDR_W-1:0];
            state_q <= ADDR;
          end
          ADDR: if (!advn_s) addr_q <= ad_s[REG_ADDR_W-1:0];
                else         state_q <= ACCESS;
          ACCESS: if (!oen_s) begin
            ad_out_q <= reg_file_q[addr_q];
            oe_q     <= 1'b1;
            state_q  <= READ;
          end else if (!wen_s) begin
            state_q <= WRITE;
          end
          READ: if (oen_s) begin
            oe_q     <= 1'b0;
            led_rd_q <= ~led_rd_q;
            addr_q   <= addr_next;
            state_q  <= ACCESS;
          end
          WRITE: if (wen_s) begin
            if (!be0n_s) reg_file_q[addr_q][7:0]  <= ad_s[7:0];
            if (!be1n_s) reg_file_q[addr_q][15:8] <= ad_s[15:8];
            wr_strobe_q <= 1'b1;
            wr_addr_q   <= addr_q;
            led_wr_q    <= ~led_wr_q;
            addr_q      <= addr_next;
            state_q     <= ACCESS;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Gate the registered enable so the pad is never driven in the cycle a
  // write strobe or chip-select release arrives.
  assign gpmc_ad_oe  = oe_q & ~csn_s & wen_s;
  assign gpmc_ad_out = ad_out_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign led         = {led_alive_q, led_rd_q, led_wr_q, (state_q != IDLE)};
  assign state_o     = state_q;

  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign regs_q[GPMC_AD_W*k +: GPMC_AD_W] = reg_file_q[k];
  end

endmodule

// File: tb/tb_gpmc_regfile_bridge.sv
// Randomized bench for gpmc_regfile_bridge against a register-array reference model.
module tb_gpmc_regfile_bridge;
  import gpmc_bridge_pkg::*;

  localparam int AW   = 4;
  localparam int SS   = 2;
  localparam int NREG = 2**AW;
  localparam int CW   = 16*NREG;
`ifdef GPMC_BRIDGE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  // clock / reset
  logic CLK_100M = 1'b0;
  logic reset    = 1'b1;
  always #5 CLK_100M = ~CLK_100M;

  logic [15:0]   gpmc_ad_in;
  logic [15:0]   gpmc_ad_out;
  logic          gpmc_ad_oe;
  logic          gpmc_advn, gpmc_csn, gpmc_wen, gpmc_oen, gpmc_be0n, gpmc_be1n;
  logic [CW-1:0] regs_q;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [3:0]    led;
  gpmc_state_e   state_o;

  gpmc_regfile_bridge #(.REG_ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .CLK_100M   (CLK_100M),
    .reset      (reset),
    .gpmc_ad_in (gpmc_ad_in),
    .gpmc_ad_out(gpmc_ad_out),
    .gpmc_ad_oe (gpmc_ad_oe),
    .gpmc_advn  (gpmc_advn),
    .gpmc_csn   (gpmc_csn),
    .gpmc_wen   (gpmc_wen),
    .gpmc_oen   (gpmc_oen),
    .gpmc_be0n  (gpmc_be0n),
    .gpmc_be1n  (gpmc_be1n),
    .regs_q     (regs_q),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .led        (led),
    .state_o    (state_o)
  );

  // scoreboard state
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [15:0]   model [NREG];
  logic [15:0]   exp_q[$];
  logic [AW-1:0] m_addr;
  logic          exp_led_wr = 1'b0;
  logic          exp_led_rd = 1'b0;
  int            strobe_cnt = 0;
  logic [AW-1:0] strobe_addr = '0;

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] model_vec();
    logic [CW-1:0] v;
    for (int k = 0; k < NREG; k++) v[16*k +: 16] = model[k];
    return v;
  endfunction

  always @(negedge CLK_100M) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_addr = wr_addr;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge CLK_100M);
    #1;
  endtask

  task automatic bus_start(input logic [15:0] raw);
    gpmc_csn   = 1'b0;
    gpmc_advn  = 1'b0;
    gpmc_ad_in = raw;
    tick(2);
    gpmc_advn  = 1'b1;
    tick(SS + 2);
    m_addr = raw[AW-1:0];
  endtask

  task automatic bus_end();
    gpmc_csn = 1'b1;
    tick(SS + 2);
    check_eq("idle_led0", led[0], 1'b0);
    check_eq("led_toggles", led[2:1], {exp_led_rd, exp_led_wr});
  endtask

  task automatic bus_write(input logic [15:0] data, input logic b0n, input logic b1n);
    strobe_cnt   = 0;
    gpmc_ad_in   = data;
    gpmc_be0n    = b0n;
    gpmc_be1n    = b1n;
    gpmc_wen     = 1'b0;
    tick(SS + 2);
    check_eq("oe_during_wen", gpmc_ad_oe, 1'b0);
    gpmc_wen = 1'b1;
    tick(SS + 2);
    gpmc_be0n = 1'b1;
    gpmc_be1n = 1'b1;
    if (!b0n) model[m_addr][7:0]  = data[7:0];
    if (!b1n) model[m_addr][15:8] = data[15:8];
    exp_led_wr = ~exp_led_wr;
    check_eq("wr_strobe_cnt", strobe_cnt, 1);
    check_eq("wr_addr", strobe_addr, m_addr);
    check_eq("regs_after_wr", regs_q, model_vec());
    if (BURST) m_addr = m_addr + 1'b1;
  endtask

  task automatic bus_read(output logic [15:0] got);
    exp_q.push_back(model[m_addr]);
    gpmc_oen = 1'b0;
    tick(SS);
    check_eq("oe_not_early", gpmc_ad_oe, 1'b0);
    tick(1);
    check_eq("oe_read", gpmc_ad_oe, 1'b1);
    got = gpmc_ad_out;
    check_eq("rd_data", got, exp_q.pop_front());
    gpmc_oen = 1'b1;
    tick(SS);
    check_eq("oe_hold", gpmc_ad_oe, 1'b1);
    tick(1);
    check_eq("oe_release", gpmc_ad_oe, 1'b0);
    exp_led_rd = ~exp_led_rd;
    if (BURST) m_addr = m_addr + 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    gpmc_ad_in = '0;
    gpmc_advn  = 1'b1; gpmc_csn  = 1'b1; gpmc_wen  = 1'b1;
    gpmc_oen   = 1'b1; gpmc_be0n = 1'b1; gpmc_be1n = 1'b1;
    for (int k = 0; k < NREG; k++) model[k] = '0;

    // reset state
    reset = 1'b1;
    tick(3);
    check_eq("rst_regs", regs_q, '0);
    check_eq("rst_oe", gpmc_ad_oe, 1'b0);
    check_eq("rst_led", led, 4'b0000);
    check_eq("rst_state", state_o, IDLE);
    check_eq("rst_ad_out", gpmc_ad_out, 16'h0000);
    reset = 1'b0;
    tick(2);
    check_eq("led_alive", led, 4'b1000);

    // full write to address 3
    bus_start(16'h0003);
    bus_write(16'hA55A, 1'b0, 1'b0);
    bus_end();
    check_eq("reg3_a55a", regs_q[63:48], 16'hA55A);

    // lower-byte-only write
    bus_start(16'h0005); bus_write(16'hFFFF, 1'b0, 1'b0); bus_end();
    bus_start(16'h0005); bus_write(16'h1234, 1'b0, 1'b1); bus_end();
    check_eq("reg5_ff34", regs_q[95:80], 16'hFF34);

    // no byte enables: register held, strobe still pulses
    bus_start(16'h0003); bus_write(16'h0F0F, 1'b1, 1'b1); bus_end();
    check_eq("reg3_no_be", regs_q[63:48], 16'hA55A);

    // read back, through an aliased address
    bus_start(16'hFF03); bus_read(rd); bus_end();
    check_eq("read_a55a", rd, 16'hA55A);

    // two writes in one chip-select starting at the top address
    bus_start(16'h000F);
    bus_write(16'h1111, 1'b0, 1'b0);
    bus_write(16'h2222, 1'b0, 1'b0);
    bus_end();
`ifdef GPMC_BRIDGE_BURST_EN
    check_eq("burst_r15", regs_q[255:240], 16'h1111);
    check_eq("burst_r0", regs_q[15:0], 16'h2222);
`else
    check_eq("nonburst_r15", regs_q[255:240], 16'h2222);
`endif

    // abort a write by releasing chip-select before wen rises
    bus_start(16'h0007);
    strobe_cnt = 0;
    gpmc_ad_in = 16'hDEAD; gpmc_be0n = 1'b0; gpmc_be1n = 1'b0;
    gpmc_wen   = 1'b0;
    tick(SS + 3);
    check_eq("abort_in_write", state_o, WRITE);
    gpmc_csn = 1'b1;
    tick(SS + 2);
    check_eq("abort_state", state_o, IDLE);
    gpmc_wen = 1'b1; gpmc_be0n = 1'b1; gpmc_be1n = 1'b1;
    tick(SS + 2);
    check_eq("abort_strobe", strobe_cnt, 0);
    check_eq("abort_regs", regs_q, model_vec());

    // randomized transactions
    for (int t = 0; t < 30; t++) begin
      int n_acc;
      bus_start(16'($urandom_range(0, 16'hFFFF)));
      n_acc = $urandom_range(1, 3);
      for (int j = 0; j < n_acc; j++) begin
        if ($urandom_range(0, 1) == 1) bus_read(rd);
        else bus_write(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      bus_end();
    end

    // reset in the middle of a read
    bus_start(16'h0003);
    gpmc_oen = 1'b0;
    tick(SS + 1);
    check_eq("pre_rst_oe", gpmc_ad_oe, 1'b1);
    reset = 1'b1;
    tick(1);
    check_eq("midrd_rst_oe", gpmc_ad_oe, 1'b0);
    check_eq("midrd_rst_regs", regs_q, '0);
    check_eq("midrd_rst_led", led, 4'b0000);
    gpmc_oen = 1'b1; gpmc_csn = 1'b1; gpmc_advn = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    check_eq("post_rst_state", state_o, IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
